// File: rtl/secp256k1_mult_arb.sv
// secp256k1_mult_arb: round-robin sharing of one 256-bit mod-p multiplier
// between several secp256k1 operation blocks. Requests are tagged with the
// requester index, results are steered back to their owner, and per-owner
// in-flight counters bound outstanding work.
module secp256k1_mult_arb #(
   parameter int N_REQ     = 2,
   parameter int CTL_BITS  = 8,
   parameter int MAX_OUTST = 4,
   parameter int IDX_BITS  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [N_REQ-1:0]             i_req_val,
   input  logic [N_REQ*512-1:0]         i_req_dat,
   input  logic [N_REQ*CTL_BITS-1:0]    i_req_ctl,
   output logic [N_REQ-1:0]             o_req_rdy,
   output logic                         o_mult_val,
   output logic [511:0]                 o_mult_dat,
   output logic [IDX_BITS+CTL_BITS-1:0] o_mult_ctl,
   input  logic                         i_mult_rdy,
   input  logic                         i_mult_val,
   input  logic [255:0]                 i_mult_dat,
   input  logic [IDX_BITS+CTL_BITS-1:0] i_mult_ctl,
   output logic                         o_mult_rdy,
   output logic [N_REQ-1:0]             o_res_val,
   output logic [255:0]                 o_res_dat,
   output logic [CTL_BITS-1:0]          o_res_ctl,
   input  logic [N_REQ-1:0]             i_res_rdy,
   output logic                         o_err
);

   // MAX_OUTST is at most 15, so four bits always suffice
   localparam int CNT_W = 4;

   logic [IDX_BITS-1:0] ptr;
   logic [CNT_W-1:0]    outst [N_REQ];
   logic [N_REQ-1:0]    eligible;
   logic                slot_free;
   logic                pick_ok;
   logic [IDX_BITS-1:0] pick_idx;
   logic                grant;
   logic [511:0]        sel_dat;
   logic [CTL_BITS-1:0] sel_ctl;
   logic [IDX_BITS-1:0] rsp_idx;
   logic                rsp_ok;
   logic                rsp_cnt_zero;
   logic                rsp_hs;
   logic                rsp_bad;

   // First eligible requester scanning upward from start (wrapping); the
   // descending loop lets the smallest offset overwrite the others.
   function automatic logic [IDX_BITS:0] rr_pick(input logic [N_REQ-1:0]    elig,
                                                 input logic [IDX_BITS-1:0] start);
      logic [IDX_BITS:0]   res;
      logic [IDX_BITS-1:0] kk;
      int                  k;
      res = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         k  = (int'(start) + i) % N_REQ;
         kk = IDX_BITS'(k);
         if (elig[kk]) res = {1'b1, kk};
      end
      return res;
   endfunction

   // In-flight counter update; a grant and a retire in the same cycle cancel
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic             inc,
                                                 input logic             dec);
      if (inc && !dec) return c + 1'b1;
      if (dec && !inc) return c - 1'b1;
      return c;
   endfunction

   // Request side: eligibility, round-robin pick and operand mux
   always_comb begin
      slot_free = !o_mult_val || i_mult_rdy;
      for (int k = 0; k < N_REQ; k++)
         eligible[k] = i_req_val[k] && (outst[k] < CNT_W'(MAX_OUTST));
      {pick_ok, pick_idx} = rr_pick(eligible, ptr);
      grant     = slot_free && pick_ok && !i_rst;
      o_req_rdy = '0;
      sel_dat   = '0;
      sel_ctl   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_idx == IDX_BITS'(k)) begin
            sel_dat      = i_req_dat[k*512 +: 512];
            sel_ctl      = i_req_ctl[k*CTL_BITS +: CTL_BITS];
            o_req_rdy[k] = grant;
         end
      end
   end

   // Response side: steer to owner; indices with no owner drain freely
   always_comb begin
      rsp_idx      = i_mult_ctl[IDX_BITS+CTL_BITS-1:CTL_BITS];
      rsp_ok       = 1'b0;
      rsp_cnt_zero = 1'b0;
      o_mult_rdy   = 1'b1;
      o_res_val    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (rsp_idx == IDX_BITS'(k)) begin
            rsp_ok       = 1'b1;
            rsp_cnt_zero = (outst[k] == '0);
            o_mult_rdy   = i_res_rdy[k];
            o_res_val[k] = i_mult_val;
         end
      end
      rsp_hs    = i_mult_val && o_mult_rdy;
      rsp_bad   = rsp_hs && (!rsp_ok || rsp_cnt_zero);
      o_res_dat = i_mult_dat;
      o_res_ctl = i_mult_ctl[CTL_BITS-1:0];
   end

   // ---- output slot toward the multiplier ----
   // Slot register and round-robin pointer; loads only when the slot is free
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_mult_val <= 1'b0;
         o_mult_dat <= '0;
         o_mult_ctl <= '0;
         ptr        <= '0;
      end else if (slot_free) begin
         o_mult_val <= grant;
         if (grant) begin
            o_mult_dat <= sel_dat;
            o_mult_ctl <= {pick_idx, sel_ctl};
            ptr        <= (pick_idx == IDX_BITS'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
         end
      end
   end

   // ---- bookkeeping ----
   // Per-owner in-flight counters and sticky error for orphan responses
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < N_REQ; k++) outst[k] <= '0;
         o_err <= 1'b0;
      end else begin
         for (int k = 0; k < N_REQ; k++)
            outst[k] <= cnt_next(outst[k],
                                 grant && (pick_idx == IDX_BITS'(k)),
                                 rsp_hs && !rsp_bad && (rsp_idx == IDX_BITS'(k)));
         if (rsp_bad) o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_secp256k1_mult_arb.sv
// Bench for secp256k1_mult_arb: directed table, hand sequences for the
// multi-cycle corners, and random traffic against a cycle reference model.
module tb_secp256k1_mult_arb;

   localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
   localparam int MAXO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    req_val = '0;
   logic [1023:0] req_dat = '0;
   logic [15:0]   req_ctl = '0;
   logic [1:0]    req_rdy;
   logic          mult_val;
   logic [511:0]  mult_dat;
   logic [8:0]    mult_ctl;
   logic          mult_rdy_in = 1'b1;
   logic          rsp_val = 1'b0;
   logic [255:0]  rsp_dat = '0;
   logic [8:0]    rsp_ctl = '0;
   logic          mult_rdy_out;
   logic [1:0]    res_val;
   logic [255:0]  res_dat;
   logic [7:0]    res_ctl;
   logic [1:0]    res_rdy = 2'b11;
   logic          err;

   // second instance with three requesters, used for out-of-range indices
   logic [2:0]    req_val3 = '0;
   logic [1535:0] req_dat3 = '0;
   logic [23:0]   req_ctl3 = '0;
   logic [2:0]    req_rdy3;
   logic          mult_val3;
   logic [511:0]  mult_dat3;
   logic [9:0]    mult_ctl3;
   logic          rsp3_val = 1'b0;
   logic [255:0]  rsp3_dat = '0;
   logic [9:0]    rsp3_ctl = '0;
   logic          mult_rdy3;
   logic [2:0]    res_val3;
   logic [255:0]  res_dat3;
   logic [7:0]    res_ctl3;
   logic [2:0]    res_rdy3 = 3'b111;
   logic          err3;

   int errors = 0;
   int checks = 0;

   secp256k1_mult_arb #(.N_REQ(2), .CTL_BITS(8), .MAX_OUTST(MAXO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_val(req_val), .i_req_dat(req_dat), .i_req_ctl(req_ctl), .o_req_rdy(req_rdy),
      .o_mult_val(mult_val), .o_mult_dat(mult_dat), .o_mult_ctl(mult_ctl), .i_mult_rdy(mult_rdy_in),
      .i_mult_val(rsp_val), .i_mult_dat(rsp_dat), .i_mult_ctl(rsp_ctl), .o_mult_rdy(mult_rdy_out),
      .o_res_val(res_val), .o_res_dat(res_dat), .o_res_ctl(res_ctl), .i_res_rdy(res_rdy),
      .o_err(err));

   secp256k1_mult_arb #(.N_REQ(3), .CTL_BITS(8), .MAX_OUTST(MAXO)) dut3 (
      .i_clk(clk), .i_rst(rst),
      .i_req_val(req_val3), .i_req_dat(req_dat3), .i_req_ctl(req_ctl3), .o_req_rdy(req_rdy3),
      .o_mult_val(mult_val3), .o_mult_dat(mult_dat3), .o_mult_ctl(mult_ctl3), .i_mult_rdy(1'b1),
      .i_mult_val(rsp3_val), .i_mult_dat(rsp3_dat), .i_mult_ctl(rsp3_ctl), .o_mult_rdy(mult_rdy3),
      .o_res_val(res_val3), .o_res_dat(res_dat3), .o_res_ctl(res_ctl3), .i_res_rdy(res_rdy3),
      .o_err(err3));

   always #5 clk = ~clk;

   // reference model state
   int           m_ptr;
   int           m_out [2];
   bit           m_val;
   logic [511:0] m_dat;
   logic [8:0]   m_ctl;
   bit           m_err;

   typedef struct {
      logic [8:0]   ctl;
      logic [255:0] r;
   } job_t;
   job_t q[$];
   bit   q_drive;

   typedef struct {
      logic [1:0] val;
      logic       mrdy;
      logic [1:0] exp_rdy;
      logic       exp_mval;
   } vec_t;
   vec_t tbl [9];

   function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] pr;
      pr = {256'd0, a} * {256'd0, b};
      pr = pr % {256'd0, P};
      return pr[255:0];
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_out[0] = 0; m_out[1] = 0;
      m_val = 0; m_dat = '0; m_ctl = '0; m_err = 0;
      q.delete(); q_drive = 0;
   endtask

   task automatic rnd_req();
      for (int w = 0; w < 32; w++) req_dat[w*32 +: 32] = $urandom();
      req_ctl = 16'($urandom());
   endtask

   // Compare all outputs against the model, then advance the model one cycle
   task automatic check_and_update();
      int         g;
      int         idx;
      logic [1:0] exp_rdy;
      logic [1:0] exp_rv;
      bit         hs, dec, free;
      free = !m_val || mult_rdy_in;
      g = -1;
      if (free) begin
         for (int i = 0; i < 2; i++) begin
            int k;
            k = (m_ptr + i) % 2;
            if (g < 0 && req_val[k] && m_out[k] < MAXO) g = k;
         end
      end
      exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
      idx     = int'(rsp_ctl[8]);
      exp_rv  = rsp_val ? 2'(1 << idx) : 2'b00;
      chk("req_rdy", req_rdy, exp_rdy);
      chk("mult_val", mult_val, m_val);
      if (m_val) begin
         chk("mult_dat", mult_dat, m_dat);
         chk("mult_ctl", mult_ctl, m_ctl);
      end
      chk("res_val", res_val, exp_rv);
      chk("mult_rdy", mult_rdy_out, res_rdy[idx]);
      chk("res_dat", res_dat, rsp_dat);
      chk("res_ctl", res_ctl, rsp_ctl[7:0]);
      chk("err", err, m_err);
      hs = rsp_val && res_rdy[idx];
      if (m_val && mult_rdy_in) q.push_back('{ctl: m_ctl, r: mulmod(m_dat[255:0], m_dat[511:256])});
      if (hs && q_drive) void'(q.pop_front());
      dec = hs && (m_out[idx] > 0);
      if (hs && !dec) m_err = 1;
      if (dec) m_out[idx]--;
      if (g >= 0) begin
         m_out[g]++;
         m_dat = req_dat[g*512 +: 512];
         m_ctl = {1'(g), req_ctl[g*8 +: 8]};
         m_ptr = (g + 1) % 2;
         m_val = 1;
      end else if (free) begin
         m_val = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_and_update();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_val = 2'b11; rsp_val = 1'b0; rsp3_val = 1'b0;
      mult_rdy_in = 1'b1; res_rdy = 2'b11;
      #1;
      chk("rst_req_rdy", req_rdy, 2'b00);
      chk("rst_mult_val", mult_val, 1'b0);
      chk("rst_mult_ctl", mult_ctl, 9'h0);
      chk("rst_err", err, 1'b0);
      chk("rst_err3", err3, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; req_val = 2'b00;
      model_reset();
   endtask

   logic [511:0] held_dat;
   logic [8:0]   held_ctl;

   initial begin
      tbl[0] = '{2'b11, 1'b1, 2'b01, 1'b0};
      tbl[1] = '{2'b11, 1'b1, 2'b10, 1'b1};
      tbl[2] = '{2'b10, 1'b1, 2'b10, 1'b1};
      tbl[3] = '{2'b11, 1'b0, 2'b00, 1'b1};
      tbl[4] = '{2'b11, 1'b1, 2'b01, 1'b1};
      tbl[5] = '{2'b01, 1'b1, 2'b01, 1'b1};
      tbl[6] = '{2'b00, 1'b1, 2'b00, 1'b1};
      tbl[7] = '{2'b00, 1'b0, 2'b00, 1'b0};
      tbl[8] = '{2'b11, 1'b0, 2'b10, 1'b0};

      do_reset();

      // single requester: a=3, b=5, tag 0x11
      req_dat = '0; req_dat[255:0] = 256'd3; req_dat[511:256] = 256'd5; req_ctl = 16'h0011;
      req_val = 2'b01;
      #1 chk("single_grant", req_rdy, 2'b01);
      tick();
      req_val = 2'b00;
      #1 chk("single_ctl", mult_ctl, 9'h011);
      chk("single_dat_a", mult_dat[255:0], 256'd3);
      tick();
      rsp_val = 1'b1; rsp_ctl = 9'h011; rsp_dat = mulmod(256'd3, 256'd5);
      #1 chk("single_res_val", res_val, 2'b01);
      chk("single_res_dat", res_dat, 256'd15);
      chk("single_res_ctl", res_ctl, 8'h11);
      tick();
      // counter is back at zero, so a second result for 0 is an orphan
      tick();
      rsp_val = 1'b0;
      #1 chk("single_outst_zero_err", err, 1'b1);
      tick();

      // directed round-robin table
      do_reset();
      for (int i = 0; i < 9; i++) begin
         req_val = tbl[i].val; mult_rdy_in = tbl[i].mrdy; rnd_req();
         #1;
         chk("tbl_req_rdy", req_rdy, tbl[i].exp_rdy);
         chk("tbl_mult_val", mult_val, tbl[i].exp_mval);
         tick();
      end

      // outstanding limit
      do_reset();
      req_val = 2'b01; mult_rdy_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rnd_req();
         #1 chk("lim_grant0", req_rdy, 2'b01);
         tick();
      end
      #1 chk("lim_blocked0", req_rdy, 2'b00);
      req_val = 2'b11;
      #1 chk("lim_grant1", req_rdy, 2'b10);
      tick();
      req_val = 2'b01; rsp_val = 1'b1; rsp_ctl = 9'h0C3; rsp_dat = 256'h1234;
      #1 chk("lim_still_blocked", req_rdy, 2'b00);
      chk("lim_rsp_rdy", mult_rdy_out, 1'b1);
      tick();
      rsp_val = 1'b0;
      #1 chk("lim_regrant0", req_rdy, 2'b01);
      tick();

      // backpressure on both sides
      do_reset();
      req_val = 2'b11; mult_rdy_in = 1'b0; rnd_req();
      tick();
      held_dat = mult_dat; held_ctl = mult_ctl;
      for (int i = 0; i < 5; i++) begin
         rnd_req();
         #1;
         chk("bp_no_grant", req_rdy, 2'b00);
         chk("bp_dat_stable", mult_dat, held_dat);
         chk("bp_ctl_stable", mult_ctl, held_ctl);
         tick();
      end
      mult_rdy_in = 1'b1; req_val = 2'b10;
      tick();
      req_val = 2'b00; rsp_val = 1'b1; rsp_ctl = 9'h1A5; rsp_dat = 256'hBEEF; res_rdy = 2'b01;
      for (int i = 0; i < 2; i++) begin
         #1 chk("bp_rsp_hold", mult_rdy_out, 1'b0);
         tick();
      end
      res_rdy = 2'b11;
      #1 chk("bp_rsp_go", mult_rdy_out, 1'b1);
      tick();
      rsp_val = 1'b0;
      tick();

      // orphan responses
      do_reset();
      rsp_val = 1'b1; rsp_ctl = 9'h133; rsp_dat = 256'h77;
      rsp3_val = 1'b1; rsp3_ctl = 10'h3AA; res_rdy3 = 3'b111;
      #1;
      chk("idx3_drain", mult_rdy3, 1'b1);
      chk("idx3_res_val", res_val3, 3'b000);
      tick();
      rsp_val = 1'b0; rsp3_val = 1'b0;
      #1;
      chk("idx1_err", err, 1'b1);
      chk("idx3_err", err3, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      #1 chk("err_sticky", err, 1'b1);

      // asynchronous reset mid-stream
      do_reset();
      req_val = 2'b01; mult_rdy_in = 1'b0; rnd_req();
      tick();
      mult_rdy_in = 1'b1; rnd_req();
      tick();
      mult_rdy_in = 1'b0; req_val = 2'b00;
      #2 rst = 1'b1;
      #1;
      chk("async_mult_val", mult_val, 1'b0);
      chk("async_req_rdy", req_rdy, 2'b00);
      @(posedge clk); #1;
      rst = 1'b0; model_reset();
      rsp_val = 1'b1; rsp_ctl = 9'h05A; rsp_dat = 256'h5A; res_rdy = 2'b11;
      tick();
      rsp_val = 1'b0; req_val = 2'b11; mult_rdy_in = 1'b1; rnd_req();
      #1;
      chk("post_rst_ptr", req_rdy, 2'b01);
      chk("stale_err", err, 1'b1);
      tick();

      // random traffic with an in-order multiplier model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req_val     = 2'($urandom());
         mult_rdy_in = ($urandom_range(0, 3) != 0);
         res_rdy[0]  = ($urandom_range(0, 3) != 0);
         res_rdy[1]  = ($urandom_range(0, 3) != 0);
         rnd_req();
         if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            rsp_val = 1'b1; rsp_ctl = q[0].ctl; rsp_dat = q[0].r; q_drive = 1;
         end else begin
            rsp_val = 1'b0; rsp_ctl = 9'($urandom()); rsp_dat = '0; q_drive = 0;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
